// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and helpers for the branch predictor
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    typedef struct packed {
        logic        valid;
        logic        uncond;
        logic [31:0] target;
    } btb_entry_t;

    function automatic bht_state_e sat_inc_dec(input bht_state_e s, input logic taken);
        if (taken)
            return (s == ST) ? ST : bht_state_e'(s + 2'b01);
        else
            return (s == SNT) ? SNT : bht_state_e'(s - 2'b01);
    endfunction

endpackage

// File: rtl/branch_unit_bp_if.sv
// rtl/branch_unit_bp_if.sv - fetch lookup and EX resolution bus of the branch unit
interface branch_unit_bp_if #(parameter int PC_W = 9);
    logic [PC_W-1:0] if_pc;
    logic            pred_taken;
    logic [31:0]     pred_target;
    logic            ex_valid;
    logic [PC_W-1:0] ex_pc;
    logic [31:0]     imm;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic [31:0]     alu_result;
    logic            ex_pred_taken;
    logic [31:0]     ex_pred_target;
    logic [31:0]     pc_imm;
    logic [31:0]     pc_four;
    logic [31:0]     br_pc;
    logic            pc_sel;
    logic            mispredict;

    modport master (
        output if_pc, ex_valid, ex_pc, imm, branch, jal, jalr, alu_result,
               ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, pc_imm, pc_four, br_pc, pc_sel, mispredict
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, imm, branch, jal, jalr, alu_result,
               ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, pc_imm, pc_four, br_pc, pc_sel, mispredict
    );
endinterface

// File: rtl/bp_table.sv
// rtl/bp_table.sv - direct-mapped BHT + BTB, one combinational read and one clocked write port
module bp_table
    import bp_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int IDX_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] rd_pc,
    output logic            rd_hit,
    output btb_entry_t      rd_entry,
    output bht_state_e      rd_bht,
    input  logic [PC_W-1:0] wr_pc,
    input  logic            bht_we,
    input  logic            wr_taken,
    input  logic            btb_we,
    input  btb_entry_t      wr_entry
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = PC_W - IDX_W - 2;

    bht_state_e       bht_mem [DEPTH];
    btb_entry_t       btb_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             unused_pc_bits;

    assign rd_idx = rd_pc[IDX_W+1:2];
    assign rd_tag = rd_pc[PC_W-1:IDX_W+2];
    assign wr_idx = wr_pc[IDX_W+1:2];
    assign wr_tag = wr_pc[PC_W-1:IDX_W+2];
    assign unused_pc_bits = ^{rd_pc[1:0], wr_pc[1:0]};

    // Read sees only registered state, so a same-cycle write to the same index is not forwarded
    assign rd_entry = btb_mem[rd_idx];
    assign rd_bht   = bht_mem[rd_idx];
    assign rd_hit   = rd_entry.valid && (tag_mem[rd_idx] == rd_tag);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bht_mem[i]       <= WNT;
                btb_mem[i].valid <= 1'b0;
            end
        end else begin
            if (bht_we)
                bht_mem[wr_idx] <= sat_inc_dec(bht_mem[wr_idx], wr_taken);
            if (btb_we)
                btb_mem[wr_idx] <= wr_entry;
        end
    end

    // Tags are qualified by the valid bit and need no reset
    always_ff @(posedge clk) begin
        if (rst_n && btb_we)
            tag_mem[wr_idx] <= wr_tag;
    end

endmodule

// File: rtl/branch_unit_bp.sv
// rtl/branch_unit_bp.sv - EX branch resolver with BHT/BTB dynamic prediction and statistics
module branch_unit_bp
    import bp_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_unit_bp_if.slave  bus,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    logic        rd_hit;
    btb_entry_t  rd_entry;
    bht_state_e  rd_bht;
    logic [31:0] pc32;
    logic        act_taken;
    logic        ctrl;
    logic        is_jal;
    logic        is_branch;
    logic        mispred;
    btb_entry_t  wr_entry;

    bp_table #(.PC_W(PC_W), .IDX_W(IDX_W)) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_pc    (bus.if_pc),
        .rd_hit   (rd_hit),
        .rd_entry (rd_entry),
        .rd_bht   (rd_bht),
        .wr_pc    (bus.ex_pc),
        .bht_we   (bus.ex_valid && is_branch),
        .wr_taken (act_taken),
        .btb_we   (bus.ex_valid && ((is_branch && act_taken) || is_jal)),
        .wr_entry (wr_entry)
    );

    assign bus.pred_taken  = rd_hit && (rd_entry.uncond || rd_bht[1]);
    assign bus.pred_target = bus.pred_taken ? rd_entry.target : 32'd0;

    // Strobe priority jalr > jal > branch decides which tables get trained
    assign is_jal    = bus.jal && !bus.jalr;
    assign is_branch = bus.branch && !bus.jal && !bus.jalr;
    assign ctrl      = bus.branch || bus.jal || bus.jalr;

    assign pc32        = {{(32-PC_W){1'b0}}, bus.ex_pc};
    assign bus.pc_imm  = bus.jalr ? bus.alu_result : pc32 + bus.imm;
    assign bus.pc_four = pc32 + 32'd4;

    assign act_taken = bus.ex_valid &&
                       ((bus.branch && bus.alu_result[0]) || bus.jal || bus.jalr);
    assign mispred   = bus.ex_valid &&
                       ((act_taken != bus.ex_pred_taken) ||
                        (act_taken && (bus.ex_pred_target != bus.pc_imm)));

    assign bus.mispredict = mispred;
    assign bus.pc_sel     = mispred;
    assign bus.br_pc      = !bus.ex_valid ? 32'd0 :
                            act_taken     ? bus.pc_imm : bus.pc_four;

    assign wr_entry = '{valid: 1'b1, uncond: is_jal, target: bus.pc_imm};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (bus.ex_valid && ctrl) begin
            branch_cnt <= branch_cnt + 1'b1;
            if (mispred)
                mispred_cnt <= mispred_cnt + 1'b1;
        end
    end

endmodule
